uart_tx_sched: RTL and testbench

Packet-level round-robin scheduler sharing one `uart_tx` transmitter between `NUM_REQ` byte-stream requesters. It sits between the requester FIFOs and `uart_tx`. Each grant is locked for a whole packet, terminated by `last`. After the packet's final frame has fully left the line, the scheduler inserts a programmable idle gap before re-arbitrating.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rr_arb.sv | 51 +++++
 rtl/uart_tx_sched.sv | 140 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
package uart_pkg;

   // Packet scheduler states.
   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StDrain,
      StGap
   } uart_sched_fsm_t;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick the lowest set bit,
// rotate the winner back to an absolute index.
module uart_rr_arb #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o
);

   localparam logic [IDX_W:0] NumReqL = (IDX_W+1)'(NUM_REQ);

   logic [NUM_REQ-1:0] req_rot;
   logic [IDX_W-1:0]   off;
   logic               found;
   logic [IDX_W:0]     sum;

   // Rotate, priority-encode from bit 0, rotate back modulo NUM_REQ.
   always_comb begin
      int unsigned pos;
      pos     = 0;
      req_rot = '0;
      off     = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pos = i + 32'(ptr_i);
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end
         req_rot[i] = req_i[IDX_W'(pos)];
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req_rot[i]) begin
            found = 1'b1;
            off   = IDX_W'(i);
         end
      end
      sum = {1'b0, off} + {1'b0, ptr_i};
      if (sum >= NumReqL) begin
         sum = sum - NumReqL;
      end
      gnt_idx_o = sum[IDX_W-1:0];
      gnt_o     = '0;
      if (found) begin
         gnt_o[gnt_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one uart_tx between NUM_REQ byte streams.
// A grant is held for a whole packet; after the final frame leaves the line a
// programmable idle gap is inserted before re-arbitrating.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned GAP_W   = 16,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 cfg_en_i,
   input  logic [GAP_W-1:0]     cfg_gap_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*8-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]   req_last_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [7:0]           tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   input  logic                 tx_busy_i,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic [IDX_W-1:0]     grant_idx_o,
   output logic                 active_o
);

   uart_sched_fsm_t    state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               active_q;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;

   uart_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i     (req_valid_i),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx)
   );

   // State, grant, pointer and gap counter registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         grant_idx_q <= '0;
         rr_ptr_q    <= '0;
         gap_cnt_q   <= '0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         gap_cnt_q   <= gap_cnt_d;
         active_q    <= (state_d != StIdle);
      end
   end

   // Next-state logic and the combinational pass-through to uart_tx.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;
      gap_cnt_d   = gap_cnt_q;
      tx_valid_o  = 1'b0;
      tx_data_o   = 8'h00;
      req_ready_o = '0;

      unique case (state_q)
         StIdle: begin
            if (cfg_en_i && (|req_valid_i)) begin
               grant_d     = arb_gnt;
               grant_idx_d = arb_idx;
               rr_ptr_d    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
               state_d     = StSend;
            end
         end
         StSend: begin
            tx_valid_o = req_valid_i[grant_idx_q];
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
               if (grant_idx_q == IDX_W'(k)) begin
                  tx_data_o = req_data_i[8*k +: 8];
               end
            end
            req_ready_o[grant_idx_q] = tx_ready_i;
            if (tx_valid_o && tx_ready_i && req_last_i[grant_idx_q]) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // uart_tx back in idle means the last stop bit has gone out.
            if (!tx_busy_i && tx_ready_i) begin
               if (cfg_gap_i == '0) begin
                  grant_d     = '0;
                  grant_idx_d = '0;
                  state_d     = StIdle;
               end else begin
                  gap_cnt_d = cfg_gap_i;
                  state_d   = StGap;
               end
            end
         end
         StGap: begin
            gap_cnt_d = gap_cnt_q - 1'b1;
            if (gap_cnt_q <= GAP_W'(1)) begin
               gap_cnt_d   = '0;
               grant_d     = '0;
               grant_idx_d = '0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Disable aborts everything but keeps the round-robin pointer.
      if (!cfg_en_i) begin
         state_d     = StIdle;
         grant_d     = '0;
         grant_idx_d = '0;
         gap_cnt_d   = '0;
         tx_valid_o  = 1'b0;
         req_ready_o = '0;
      end
   end

   assign grant_o     = grant_q;
   assign grant_idx_o = grant_idx_q;
   assign active_o    = active_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural uart_tx stand-in and
// per-requester packet sources.
module tb_uart_tx_sched;

   localparam int unsigned NumReq = 4;
   localparam int unsigned GapW   = 16;
   localparam int unsigned Frame  = 30;

   logic                 clk;
   logic                 rst_n;
   logic                 cfg_en;
   logic [GapW-1:0]      cfg_gap;
   logic [NumReq-1:0]    req_valid, req_last, req_ready;
   logic [NumReq*8-1:0]  req_data;
   logic [7:0]           tx_data;
   logic                 tx_valid, tx_ready, tx_busy;
   logic [NumReq-1:0]    grant;
   logic [1:0]           grant_idx;
   logic                 active;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Packet sources: requester k offers pbytes[k][0..plen-1] starting at sent == pstart.
   int unsigned sent   [NumReq] = '{default: 0};
   int unsigned pstart [NumReq];
   int unsigned plen   [NumReq];
   logic [7:0]  pbytes [NumReq][8];

   // uart_tx stand-in.
   logic        m_busy, m_ready;
   int unsigned m_cnt;
   logic [7:0]  line_q[$];

   assign tx_ready = m_ready;
   assign tx_busy  = m_busy;

   uart_tx_sched #(
      .NUM_REQ (NumReq),
      .GAP_W   (GapW)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .cfg_en_i    (cfg_en),
      .cfg_gap_i   (cfg_gap),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .tx_data_o   (tx_data),
      .tx_valid_o  (tx_valid),
      .tx_ready_i  (tx_ready),
      .tx_busy_i   (tx_busy),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .active_o    (active)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Source outputs derived from how many bytes of the current packet were taken.
   always_comb begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      for (int k = 0; k < NumReq; k++) begin
         if (sent[k] - pstart[k] < plen[k]) begin
            req_valid[k]        = 1'b1;
            req_data[8*k +: 8]  = pbytes[k][3'(sent[k] - pstart[k])];
            req_last[k]         = (sent[k] - pstart[k] == plen[k] - 1);
         end
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < NumReq; k++) begin
         if (req_valid[k] && req_ready[k]) sent[k] <= sent[k] + 1;
      end
   end

   // Accept a byte when idle, stay busy for a frame, then report ready again.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_ready <= 1'b1;
         m_cnt   <= 0;
      end else if (m_busy) begin
         if (m_cnt == 0) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if (tx_valid && tx_ready) begin
         m_busy  <= 1'b1;
         m_ready <= 1'b0;
         m_cnt   <= Frame - 2;
         line_q.push_back(tx_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting", nm);
   endtask

   task automatic load(input logic [1:0] k, input int unsigned n,
                       input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      pstart[k]    = sent[k];
      plen[k]      = n;
      pbytes[k][0] = b0;
      pbytes[k][1] = b1;
      pbytes[k][2] = b2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (active && n < 2000) begin tick(); n++; end
      if (n >= 2000) timeout(nm);
   endtask

   task automatic wait_quiet(input string nm);
      int n = 0;
      while ((active || (|req_valid)) && n < 4000) begin tick(); n++; end
      if (n >= 4000) timeout(nm);
   endtask

   task automatic wait_line(input int sz, input string nm);
      int n = 0;
      while (line_q.size() < sz && n < 2000) begin tick(); n++; end
      if (n >= 2000) timeout(nm);
   endtask

   task automatic wait_grant(input logic [1:0] k, input string nm);
      int n = 0;
      while (!grant[k] && n < 2000) begin tick(); n++; end
      if (n >= 2000) timeout(nm);
   endtask

   task automatic wait_busy(input logic val, input string nm);
      int n = 0;
      while (tx_busy !== val && n < 2000) begin tick(); n++; end
      if (n >= 2000) timeout(nm);
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n, bad, last_busy, idle_n, sz;

      vecs[0] = '{4'b1111, 4'b0001, 2'd0};
      vecs[1] = '{4'b1111, 4'b0010, 2'd1};
      vecs[2] = '{4'b1111, 4'b0100, 2'd2};
      vecs[3] = '{4'b1111, 4'b1000, 2'd3};
      vecs[4] = '{4'b1111, 4'b0001, 2'd0};
      vecs[5] = '{4'b0001, 4'b0001, 2'd0};
      vecs[6] = '{4'b1001, 4'b1000, 2'd3};
      vecs[7] = '{4'b0110, 4'b0010, 2'd1};
      vecs[8] = '{4'b0011, 4'b0001, 2'd0};
      vecs[9] = '{4'b0100, 4'b0100, 2'd2};

      for (int k = 0; k < NumReq; k++) begin
         pstart[k] = 0;
         plen[k]   = 0;
      end
      last_busy = 0;
      cfg_en  = 1'b1;
      cfg_gap = '0;
      do_reset();

      // Reset values.
      chk("rst_grant", 32'(grant), 0);
      chk("rst_idx", 32'(grant_idx), 0);
      chk("rst_active", 32'(active), 0);
      chk("rst_txvalid", 32'(tx_valid), 0);
      chk("rst_txdata", 32'(tx_data), 0);
      chk("rst_ready", 32'(req_ready), 0);

      // Single 3-byte packet, gap of 10.
      cfg_gap = 16'd10;
      load(2'd0, 3, 8'h11, 8'h22, 8'h33);
      wait_line(3, "a_bytes");
      chk("a_drain_active", 32'(active), 1);
      chk("a_drain_txvalid", 32'(tx_valid), 0);
      chk("a_drain_grant", 32'(grant), 32'b0001);
      chk("a_drain_busy", 32'(tx_busy), 1);
      wait_busy(1'b0, "a_busy_fall");
      n = 0;
      while (active && n < 100) begin tick(); n++; end
      chk("a_drain_gap_cycles", n, 11);
      chk("a_grant_after", 32'(grant), 0);
      chk("a_byte0", 32'(line_q[0]), 32'h11);
      chk("a_byte1", 32'(line_q[1]), 32'h22);
      chk("a_byte2", 32'(line_q[2]), 32'h33);

      // Round-robin table, 1-byte packets, gap 0, pointer starting from 0.
      do_reset();
      cfg_gap = '0;
      for (int i = 0; i < 10; i++) begin
         base = line_q.size();
         for (int k = 0; k < NumReq; k++) begin
            load(2'(k), vecs[i].req[k] ? 1 : 0, 8'(160 + k), 8'h00, 8'h00);
         end
         tick();
         chk($sformatf("rr%0d_grant", i), 32'(grant), 32'(vecs[i].gnt));
         chk($sformatf("rr%0d_idx", i), 32'(grant_idx), 32'(vecs[i].idx));
         chk($sformatf("rr%0d_onehot", i), 32'($onehot(grant)), 1);
         chk($sformatf("rr%0d_txvalid", i), 32'(tx_valid), 1);
         chk($sformatf("rr%0d_txdata", i), 32'(tx_data), 32'(160 + vecs[i].idx));
         chk($sformatf("rr%0d_ready", i), 32'(req_ready), 32'(vecs[i].gnt));
         tick();
         wait_idle($sformatf("rr%0d_idle", i));
         chk($sformatf("rr%0d_line", i), 32'(line_q[base]), 32'(160 + vecs[i].idx));
      end
      for (int k = 0; k < NumReq; k++) load(2'(k), 0, 8'h00, 8'h00, 8'h00);
      wait_quiet("rr_quiet");

      // Requester 2 mid-packet; requester 0 must wait for its end plus the gap.
      cfg_gap = 16'd5;
      load(2'd2, 3, 8'h21, 8'h22, 8'h23);
      wait_grant(2'd2, "c_grant2");
      base = line_q.size();
      wait_line(base + 1, "c_first");
      load(2'd0, 1, 8'h55, 8'h00, 8'h00);
      n = 0;
      bad = 0;
      while (!grant[0] && n < 1000) begin
         if (tx_busy) last_busy = cyc;
         if (req_ready[0]) bad++;
         tick();
         n++;
      end
      if (n >= 1000) timeout("c_grant0");
      chk("c_no_early_ready0", bad, 0);
      chk("c_req2_done", sent[2] - pstart[2], 3);
      chk("c_grant0_delay", cyc - last_busy, 8);
      wait_quiet("c_quiet");
      sz = line_q.size();
      chk("c_line_last2", 32'(line_q[sz - 2]), 32'h23);
      chk("c_line_req0", 32'(line_q[sz - 1]), 32'h55);

      // Zero gap: DRAIN straight to IDLE.
      cfg_gap = '0;
      load(2'd1, 1, 8'h61, 8'h00, 8'h00);
      load(2'd3, 1, 8'h63, 8'h00, 8'h00);
      tick();
      chk("d_grant1", 32'(grant), 32'b0010);
      n = 0;
      idle_n = 0;
      while (!grant[3] && n < 1000) begin
         if (tx_busy) last_busy = cyc;
         if (!active) idle_n++;
         tick();
         n++;
      end
      if (n >= 1000) timeout("d_grant3");
      chk("d_idle_cycles", idle_n, 1);
      chk("d_grant3_delay", cyc - last_busy, 3);
      wait_quiet("d_quiet");
      sz = line_q.size();
      chk("d_line0", 32'(line_q[sz - 2]), 32'h61);
      chk("d_line1", 32'(line_q[sz - 1]), 32'h63);

      // Disable during SEND after the first of three bytes.
      load(2'd2, 3, 8'h71, 8'h72, 8'h73);
      tick();
      chk("e_grant2", 32'(grant), 32'b0100);
      base = line_q.size();
      wait_line(base + 1, "e_first");
      n = 0;
      while (!tx_ready && n < 1000) begin tick(); n++; end
      if (n >= 1000) timeout("e_ready");
      chk("e_ready_before", 32'(req_ready), 32'b0100);
      cfg_en = 1'b0;
      #1;
      chk("e_txvalid_drop", 32'(tx_valid), 0);
      chk("e_ready_drop", 32'(req_ready), 0);
      tick();
      chk("e_active_off", 32'(active), 0);
      chk("e_grant_off", 32'(grant), 0);
      load(2'd3, 1, 8'h74, 8'h00, 8'h00);
      cfg_en = 1'b1;
      tick();
      chk("e_rr_kept", 32'(grant), 32'b1000);
      wait_grant(2'd2, "e_regrant2");
      chk("e_resume_data", 32'(tx_data), 32'h72);
      wait_quiet("e_quiet");
      sz = line_q.size();
      chk("e_line0", 32'(line_q[sz - 4]), 32'h71);
      chk("e_line1", 32'(line_q[sz - 3]), 32'h74);
      chk("e_line2", 32'(line_q[sz - 2]), 32'h72);
      chk("e_line3", 32'(line_q[sz - 1]), 32'h73);

      // Asynchronous reset while in GAP.
      cfg_gap = 16'd20;
      load(2'd1, 1, 8'h81, 8'h00, 8'h00);
      tick();
      chk("f_grant1", 32'(grant), 32'b0010);
      wait_busy(1'b1, "f_busy_rise");
      wait_busy(1'b0, "f_busy_fall");
      tick();
      tick();
      chk("f_in_gap", 32'(active), 1);
      load(2'd0, 1, 8'h90, 8'h00, 8'h00);
      load(2'd3, 1, 8'h93, 8'h00, 8'h00);
      rst_n = 1'b0;
      #1;
      chk("f_rst_grant", 32'(grant), 0);
      chk("f_rst_idx", 32'(grant_idx), 0);
      chk("f_rst_active", 32'(active), 0);
      chk("f_rst_txvalid", 32'(tx_valid), 0);
      chk("f_rst_txdata", 32'(tx_data), 0);
      chk("f_rst_ready", 32'(req_ready), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("f_first_grant", 32'(grant), 32'b0001);
      chk("f_first_idx", 32'(grant_idx), 0);
      wait_quiet("f_quiet");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
